// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared external multiplier; returns each product tagged to its requester.
// Optional MULT_ARBITER_STATS_EN adds a saturating 32-bit transfer counter on o_grant_count.
module mult_arbiter #(
  parameter int W_a      = 8,
  parameter int W_b      = 8,
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*W_a-1:0]   i_req_a,
  input  logic [N_REQ*W_b-1:0]   i_req_b,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [W_a-1:0]         o_mult_a,
  output logic [W_b-1:0]         o_mult_b,
  input  logic [W_a+W_b-1:0]     i_mult_product,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [W_a+W_b-1:0]     o_rsp_product
`ifdef MULT_ARBITER_STATS_EN
  ,
  output logic [31:0]            o_grant_count
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]             r_ptr;
  logic [MULT_LAT:0]            r_tag_v;
  logic [MULT_LAT:0][IDX_W-1:0] r_tag_idx;
  logic [W_a-1:0]               r_mult_a;
  logic [W_b-1:0]               r_mult_b;

  logic                         w_grant;
  logic [IDX_W-1:0]             w_idx;
  int                           w_j;

  // Scan from the pointer upward with wrap; the first pending requester wins.
  always_comb begin
    w_grant = 1'b0;
    w_idx   = '0;
    w_j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!w_grant && i_req_valid[w_j]) begin
        w_grant = 1'b1;
        w_idx   = IDX_W'(w_j);
      end
    end
    if (i_rst) w_grant = 1'b0;
  end

  always_comb begin
    o_req_ready = '0;
    if (w_grant) o_req_ready[w_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr     <= '0;
      r_tag_v   <= '0;
      r_tag_idx <= '0;
      r_mult_a  <= '0;
      r_mult_b  <= '0;
    end else begin
      r_tag_v <= {r_tag_v[MULT_LAT-1:0], w_grant};
      for (int s = MULT_LAT; s > 0; s--) r_tag_idx[s] <= r_tag_idx[s-1];
      r_tag_idx[0] <= w_idx;
      if (w_grant) begin
        r_mult_a <= i_req_a[w_idx*W_a +: W_a];
        r_mult_b <= i_req_b[w_idx*W_b +: W_b];
        r_ptr    <= (int'(w_idx) == N_REQ-1) ? '0 : w_idx + 1'b1;
      end
    end
  end

  assign o_mult_a      = r_mult_a;
  assign o_mult_b      = r_mult_b;
  assign o_rsp_product = i_mult_product;

  // Tag at the last stage lines up with the multiplier output for that grant.
  always_comb begin
    o_rsp_valid = '0;
    if (!i_rst && r_tag_v[MULT_LAT]) o_rsp_valid[r_tag_idx[MULT_LAT]] = 1'b1;
  end

`ifdef MULT_ARBITER_STATS_EN
  logic [31:0] r_grant_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant_count <= '0;
    end else if (w_grant && (r_grant_count != 32'hFFFF_FFFF)) begin
      r_grant_count <= r_grant_count + 32'd1;
    end
  end

  assign o_grant_count = r_grant_count;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural shared multiplier of latency LAT.
// Stats checks are compiled in when MULT_ARBITER_STATS_EN is defined.
module tb_mult_arbiter;
  localparam int WA  = 8;
  localparam int WB  = 8;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*WA-1:0]   req_a;
  logic [N*WB-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic [WA-1:0]     mult_a;
  logic [WB-1:0]     mult_b;
  logic [WA+WB-1:0]  mult_product;
  logic [N-1:0]      rsp_valid;
  logic [WA+WB-1:0]  rsp_product;
`ifdef MULT_ARBITER_STATS_EN
  logic [31:0]       grant_count;
`endif

  mult_arbiter #(.W_a(WA), .W_b(WB), .N_REQ(N), .MULT_LAT(LAT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .o_req_ready    (req_ready),
    .o_mult_a       (mult_a),
    .o_mult_b       (mult_b),
    .i_mult_product (mult_product),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_product  (rsp_product)
`ifdef MULT_ARBITER_STATS_EN
    ,
    .o_grant_count  (grant_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: LAT register stages after mult_a/mult_b.
  logic [WA+WB-1:0] mul_pipe [LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= mult_a * mult_b;
    for (int s = 1; s < LAT; s++) mul_pipe[s] <= mul_pipe[s-1];
  end
  assign mult_product = mul_pipe[LAT-1];

  typedef struct {
    int               idx;
    logic [WA+WB-1:0] prod;
    int               due;
  } rsp_t;

  rsp_t        sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          m_ptr = 0;
  int          last_g = -1;
  logic [WA-1:0] m_a = '0;
  logic [WB-1:0] m_b = '0;
  longint      m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    logic [N-1:0]     exp_ready;
    logic [N-1:0]     exp_rv;
    logic [WA+WB-1:0] exp_p;
    rsp_t             e;
    int               g;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));

    if (rst) sb_q.delete();
    exp_rv = '0;
    exp_p  = '0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      exp_rv[e.idx] = 1'b1;
      exp_p = e.prod;
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv != '0) check_eq("rsp_product", 32'(rsp_product), 32'(exp_p));
    check_eq("mult_a", 32'(mult_a), 32'(m_a));
    check_eq("mult_b", 32'(mult_b), 32'(m_b));
`ifdef MULT_ARBITER_STATS_EN
    check_eq("grant_count", grant_count, 32'(m_cnt));
`endif

    if (rst) begin
      m_ptr = 0; m_a = '0; m_b = '0; m_cnt = 0;
    end else if (g >= 0) begin
      e.idx  = g;
      e.prod = (WA+WB)'(req_a[g*WA +: WA]) * (WA+WB)'(req_b[g*WB +: WB]);
      e.due  = cyc + 1 + LAT;
      sb_q.push_back(e);
      m_a   = req_a[g*WA +: WA];
      m_b   = req_b[g*WB +: WB];
      m_ptr = (g + 1) % N;
      if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*WA +: WA] = WA'(a);
    req_b[i*WB +: WB] = WB'(b);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);

    // 255*255 single transfer
    set_op(0, 255, 255);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (3) tick();

    // all four pending, operands held
    do_reset(1);
    set_op(0, 17, 99); set_op(1, 178, 78); set_op(2, 222, 0); set_op(3, 1, 3);
    req_valid = 4'b1111;
    repeat (4) tick();
    req_valid = '0;
    repeat (3) tick();

    // two sparse requesters alternate
    req_valid = 4'b1010;
    repeat (6) tick();
    req_valid = '0;
    repeat (3) tick();

    // reset right after a transfer from requester 2 flushes it and rewinds the pointer
    set_op(2, 69, 69);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    do_reset(1);
    req_valid = 4'b1111;
    tick();
    req_valid = '0;
    repeat (4) tick();

    // bubbles between transfers
    set_op(0, 10, 10);
    for (int r = 0; r < 6; r++) begin
      req_valid = (r % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (3) tick();

    // random traffic; requesters hold until granted
    for (int r = 0; r < 300; r++) begin
      if (last_g >= 0) req_valid[last_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) != 0)) begin
          req_valid[i] = 1'b1;
          set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
      tick();
    end
    req_valid = '0;

    for (int r = 0; r < 10 && sb_q.size() > 0; r++) tick();
    check_eq("drain_empty", 32'(sb_q.size()), 32'd0);

`ifdef MULT_ARBITER_STATS_EN
    do_reset(1);
    set_op(1, 3, 4);
    req_valid = 4'b0010;
    repeat (10) tick();
    req_valid = '0;
    repeat (3) tick();
    check_eq("grant_count_10", grant_count, 32'd10);
    do_reset(1);
    tick();
    check_eq("grant_count_clr", grant_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter W_a, default 8: bit-width of operand a.
REQ-002 Parameter W_b, default 8: bit-width of operand b.
REQ-003 Parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-004 Parameter MULT_LAT, default 1: cycles from mult_a/mult_b presented to mult_product valid; legal range 1..8.
REQ-005 Clock  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  N_REQ  bit i = requester i has an operand pair pending.
REQ-008 req_a  input  N_REQ*W_a  packed operand a; requester i at [i*W_a +: W_a].
REQ-009 req_b  input  N_REQ*W_b  packed operand b; requester i at [i*W_b +: W_b].
REQ-010 req_ready  output  N_REQ  one-hot-or-zero grant; combinational from req_valid and the priority pointer.
REQ-011 mult_a  output  W_a  registered operand a to the shared multiplier.
REQ-012 mult_b  output  W_b  registered operand b to the shared multiplier.
REQ-013 mult_product  input  W_a+W_b  full-width unsigned product from the shared multiplier.
REQ-014 rsp_valid  output  N_REQ  one-hot-or-zero; bit i = rsp_product belongs to requester i this cycle.
REQ-015 rsp_product  output  W_a+W_b  product returned; equals mult_product.

Function
REQ-016 Transfer from requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-017 At most one req_ready bit SHALL be high per cycle; req_ready[i] SHALL be 0 whenever req_valid[i] is 0.
REQ-018 Arbitration SHALL be round-robin: grant the lowest index at or above pointer p with req_valid set, wrapping from N_REQ-1 to 0.
REQ-019 After a grant to i, p SHALL become (i+1) mod N_REQ; with no grant, p SHALL be unchanged.
REQ-020 Requesters hold req_valid and operands stable until granted; the block SHALL NOT latch un-granted operands.
REQ-021 On a transfer in cycle T, mult_a/mult_b SHALL carry the granted operands in cycle T+1; without a transfer they SHALL hold their previous values.
REQ-022 A tag pipeline of depth 1+MULT_LAT SHALL carry {valid, requester index}; rsp_valid[i] SHALL assert exactly in cycle T+1+MULT_LAT for a transfer from i in cycle T.
REQ-023 Throughput SHALL be one transfer per cycle; rsp path has no backpressure; responses SHALL return in grant order.
REQ-024 Products SHALL be unsigned and full-width (W_a+W_b bits); no truncation or saturation.
REQ-025 Bubbles (no transfer) SHALL propagate as rsp_valid = 0 in the corresponding cycle.

Reset
REQ-026 While Reset is 1: p = 0, tag pipeline cleared, mult_a = 0, mult_b = 0, rsp_valid = 0, req_ready = 0.
REQ-027 Reset mid-operation SHALL discard all in-flight products: no rsp_valid for any transfer accepted before Reset deasserts.
REQ-028 The first cycle after Reset deasserts SHALL arbitrate normally with p = 0.

Configuration
REQ-029 Macro MULT_ARBITER_STATS_EN defined: output grant_count (32 bits) SHALL count transfers, saturate at 2^32-1, and clear on Reset.
REQ-030 Macro MULT_ARBITER_STATS_EN undefined: port grant_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 MULT_LAT=1, req_valid=0001, a=255, b=255 granted in T -> rsp_valid=0001, rsp_product=65025 in T+2.
REQ-032 After Reset, req_valid=1111 held, operands (17,99),(178,78),(222,0),(1,3) -> grants 0,1,2,3 on consecutive cycles; products 1683,13884,0,3 returned in that order.
REQ-033 req_valid=1010 held continuously -> grants alternate 1,3,1,3; req_ready[0] and req_ready[2] never asserted.
REQ-034 Transfer (69,69) in T, Reset asserted in T+1 for one cycle -> no rsp_valid bit ever asserted for it; next grant starts from requester 0.
REQ-035 Idle cycles interleaved with transfers of (10,10) -> rsp_valid = 0 in bubble cycles, 100 returned with correct latency, mult_a/mult_b unchanged during bubbles.
REQ-036 With MULT_ARBITER_STATS_EN defined, 10 transfers -> grant_count = 10; Reset -> grant_count = 0.
